scalar_ex_issue_buffer: RTL

//  Two-entry skid buffer between scalar decode and the scalar ALU in the Execute stage.

---
 rtl/scalar_ex_pkg.sv | 49 ++++
 rtl/scalar_ex_issue_buffer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/scalar_ex_pkg.sv
// Shared types for the scalar Execute-stage issue buffer.
// Holds the op bundle, the buffer state enum and the ALU function codes.
package scalar_ex_pkg;

    localparam int OP_W = 16;
    localparam int RD_W = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic [2:0]      f;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            divz;
    } scalar_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // Divide-by-zero is resolved at capture so the writeback can be
    // squashed without any logic on the registered output path.
    function automatic scalar_op_t make_op(
        input logic [OP_W-1:0] a,
        input logic [OP_W-1:0] b,
        input logic [2:0]      f,
        input logic [RD_W-1:0] rd,
        input logic            we
    );
        scalar_op_t op;
        op.a    = a;
        op.b    = b;
        op.f    = f;
        op.rd   = rd;
        op.divz = (f == ALU_DIV) && (b == '0);
        op.we   = we & ~op.divz;
        return op;
    endfunction

endpackage

// File: rtl/scalar_ex_issue_buffer.sv
// Two-entry skid buffer between scalar decode and the scalar ALU.
// Main register drives the ALU; skid register absorbs one stalled op.
module scalar_ex_issue_buffer
    import scalar_ex_pkg::*;
#(
    parameter int N  = OP_W,
    parameter int RW = RD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [2:0]    in_f,
    input  logic [RW-1:0] in_rd,
    input  logic          in_we,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic [2:0]    out_f,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_divz
);

    buf_state_t state_q;
    buf_state_t state_d;

    scalar_op_t main_q;
    scalar_op_t skid_q;
    scalar_op_t in_op;

    logic in_ready_q;
    logic out_valid_q;
    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;
    assign in_op    = make_op(in_a, in_b, in_f, in_rd, in_we);

    // State register plus the registered handshake flags derived from next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
        end
    end

    // Next-state: occupancy tracking, flush always empties
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)
                        state_d = FULL;
                    else if (!in_fire && out_fire)
                        state_d = EMPTY;
                end
                FULL: if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Datapath load enables; a flushed cycle loads nothing
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (!flush) begin
            unique case (state_q)
                EMPTY: load_main_in = in_fire;
                ONE: begin
                    load_main_in = in_fire & out_fire;
                    load_skid    = in_fire & ~out_fire;
                end
                FULL: load_main_skid = out_fire;
                default: ;
            endcase
        end
    end

    // Payload registers; main holds stable until a load is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= in_op;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_op;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_a     = main_q.a;
    assign out_b     = main_q.b;
    assign out_f     = main_q.f;
    assign out_rd    = main_q.rd;
    assign out_we    = main_q.we;
    assign out_divz  = main_q.divz;

endmodule
